// File: rtl/shift_arbiter.sv
// shift_arbiter: two-requester front end for a shared 16-bit SLL/SRA barrel shifter.
// Accepted operations pass through an operand stage (S1), the shifter, and a
// result stage (S2). Each result is routed back to the requester that issued it,
// and results leave in acceptance order. At most two operations are in flight.
// Build option SHIFT_ARB_FIXED_PRIO_EN: when defined, Req0 always wins a conflict
// and last_gnt stays at its reset value. When undefined (default), conflicts
// alternate through last_gnt.
module shift_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        Req0_Valid,
    output logic        Req0_Ready,
    input  logic [15:0] Req0_In,
    input  logic [3:0]  Req0_Val,
    input  logic        Req0_Mode,
    input  logic        Req1_Valid,
    output logic        Req1_Ready,
    input  logic [15:0] Req1_In,
    input  logic [3:0]  Req1_Val,
    input  logic        Req1_Mode,
    output logic        Rsp0_Valid,
    input  logic        Rsp0_Ready,
    output logic [15:0] Rsp0_Out,
    output logic        Rsp1_Valid,
    input  logic        Rsp1_Ready,
    output logic [15:0] Rsp1_Out,
    output logic        Busy
);

    logic        s1_valid;
    logic        s1_tag;
    logic [15:0] s1_in;
    logic [3:0]  s1_val;
    logic        s1_mode;

    logic        s2_valid;
    logic        s2_tag;
    logic [15:0] s2_result;

    logic        last_gnt;

    logic        s2_free;
    logic        s1_free;
    logic        grant;
    logic        accept;
    logic [15:0] acc_in;
    logic [3:0]  acc_val;
    logic        acc_mode;
    logic [15:0] sll_result;
    logic [15:0] sra_result;
    logic [15:0] shift_result;

    // Stage-advance conditions, the grant decision and the handshake outputs
    always_comb begin
        s2_free = !s2_valid || (s2_tag ? Rsp1_Ready : Rsp0_Ready);
        s1_free = !s1_valid || s2_free;
`ifdef SHIFT_ARB_FIXED_PRIO_EN
        grant = !Req0_Valid;
`else
        if (Req0_Valid && Req1_Valid) begin
            grant = !last_gnt;
        end else begin
            grant = Req1_Valid;
        end
`endif
        Req0_Ready = Req0_Valid && !grant && s1_free;
        Req1_Ready = Req1_Valid &&  grant && s1_free;
        accept     = Req0_Ready || Req1_Ready;
        acc_in     = grant ? Req1_In   : Req0_In;
        acc_val    = grant ? Req1_Val  : Req0_Val;
        acc_mode   = grant ? Req1_Mode : Req0_Mode;
    end

    // Barrel shifter on the S1 operands; the SRA path is kept separate so it stays signed
    always_comb begin
        sll_result   = s1_in << s1_val;
        sra_result   = $signed(s1_in) >>> s1_val;
        shift_result = s1_mode ? sra_result : sll_result;
    end

    // Operand stage: loads on an accepted request, empties when its content moves to S2
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_tag   <= 1'b0;
            s1_in    <= 16'h0000;
            s1_val   <= 4'h0;
            s1_mode  <= 1'b0;
        end else if (s1_free) begin
            s1_valid <= accept;
            if (accept) begin
                s1_tag  <= grant;
                s1_in   <= acc_in;
                s1_val  <= acc_val;
                s1_mode <= acc_mode;
            end
        end
    end

    // Result stage: holds until the addressed requester takes the result
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_tag    <= 1'b0;
            s2_result <= 16'h0000;
        end else if (s2_free) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_tag    <= s1_tag;
                s2_result <= shift_result;
            end
        end
    end

    // Remember who was granted last so the other requester wins the next conflict
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= 1'b1;
        end else begin
`ifdef SHIFT_ARB_FIXED_PRIO_EN
            last_gnt <= 1'b1;
`else
            if (accept) begin
                last_gnt <= grant;
            end
`endif
        end
    end

    // Both response channels show the S2 result; only the tagged one is valid
    always_comb begin
        Rsp0_Valid = s2_valid && !s2_tag;
        Rsp1_Valid = s2_valid &&  s2_tag;
        Rsp0_Out   = s2_result;
        Rsp1_Out   = s2_result;
        Busy       = s1_valid || s2_valid;
    end

endmodule
